// File: rtl/serial_adder_4bit.sv
// Bit-serial adder: {co,s} = a + b + ci, one bit per clock, LSB first,
// through a single full-adder cell and a 1-bit carry register.
module serial_adder_4bit #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] s,
    output logic             co
);

    localparam int CW = $clog2(WIDTH) + 1;
    localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [WIDTH-1:0] s_q, s_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             carry_q, carry_d;
    logic             co_q, co_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic             fa_x, fa_y, fa_sum, fa_cout;

    // Full-adder cell on the current LSBs and the carry register
    always_comb begin
        fa_x    = a_sr_q[0];
        fa_y    = b_sr_q[0];
        fa_sum  = fa_x ^ fa_y ^ carry_q;
        fa_cout = ((fa_x ^ fa_y) & carry_q) | (fa_x & fa_y);
    end

    // Next-state logic: operand load, serial step, and final result capture
    always_comb begin
        state_d = state_q;
        a_sr_d  = a_sr_q;
        b_sr_d  = b_sr_q;
        res_d   = res_q;
        s_d     = s_q;
        cnt_d   = cnt_q;
        carry_d = carry_q;
        co_d    = co_q;
        busy_d  = 1'b0;
        done_d  = 1'b0;
        case (state_q)
            IDLE, DONE: begin
                // DONE behaves like IDLE for start so operations can run back-to-back
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    carry_d = ci;
                    res_d   = '0;
                    cnt_d   = '0;
                    state_d = RUN;
                    busy_d  = 1'b1;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_sr_d  = a_sr_q >> 1;
                b_sr_d  = b_sr_q >> 1;
                res_d   = {fa_sum, res_q[WIDTH-1:1]};
                carry_d = fa_cout;
                cnt_d   = cnt_q + CW'(1);
                if (cnt_q == LAST_BIT) begin
                    // s/co only ever change here, so partial sums stay hidden
                    s_d     = {fa_sum, res_q[WIDTH-1:1]};
                    co_d    = fa_cout;
                    state_d = DONE;
                    done_d  = 1'b1;
                end else begin
                    busy_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State and registered outputs; reset clears everything without a clock
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            a_sr_q  <= '0;
            b_sr_q  <= '0;
            res_q   <= '0;
            s_q     <= '0;
            cnt_q   <= '0;
            carry_q <= 1'b0;
            co_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            a_sr_q  <= a_sr_d;
            b_sr_q  <= b_sr_d;
            res_q   <= res_d;
            s_q     <= s_d;
            cnt_q   <= cnt_d;
            carry_q <= carry_d;
            co_q    <= co_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign s    = s_q;
    assign co   = co_q;

endmodule

// File: tb/tb_serial_adder_4bit.sv
// Bench for serial_adder_4bit: cycle-level behavioural model plus directed
// literal cases, randomized traffic and an exhaustive operand sweep.
module tb_serial_adder_4bit;

    localparam int W = 4;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         ci = 1'b0;
    logic         busy, done, co;
    logic [W-1:0] s;

    int tests = 0;
    int fails = 0;

    serial_adder_4bit #(.WIDTH(W)) dut (
        .clk(clk), .rst(rst), .start(start), .a(a), .b(b), .ci(ci),
        .busy(busy), .done(done), .s(s), .co(co)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    // Model: an accepted start yields a result W edges later; sum by plain arithmetic
    int           m_left = 0;
    int           m_pend = 0;
    logic         m_done = 1'b0;
    logic [W-1:0] m_s = '0;
    logic         m_co = 1'b0;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_left <= 0;
            m_done <= 1'b0;
            m_s    <= '0;
            m_co   <= 1'b0;
        end else if (m_left > 0) begin
            m_left <= m_left - 1;
            if (m_left == 1) begin
                m_done <= 1'b1;
                m_s    <= m_pend[W-1:0];
                m_co   <= m_pend[W];
            end
        end else begin
            m_done <= 1'b0;
            if (start) begin
                m_left <= W;
                m_pend <= int'(a) + int'(b) + int'(ci);
            end
        end
    end

    // Every-cycle comparison against the model
    always @(negedge clk) begin
        chk("busy", busy, (m_left > 0));
        chk("done", done, m_done);
        chk("s", s, m_s);
        chk("co", co, m_co);
        chk("busy_done_excl", busy & done, 0);
    end

    // One operation from IDLE; returns result, busy cycles and edges to done
    task automatic run_op(input logic [W-1:0] ta, input logic [W-1:0] tb,
                          input logic tci, output logic [W-1:0] rs,
                          output logic rco, output int bc, output int edges);
        logic got;
        got   = 1'b0;
        bc    = 0;
        edges = 0;
        @(negedge clk);
        start = 1'b1; a = ta; b = tb; ci = tci;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk);
            edges++;
            @(negedge clk);
            start = 1'b0;
            if (done) got = 1'b1;
            else if (busy) bc++;
        end
        if (!got) chk("done_timeout", 0, 1);
        rs  = s;
        rco = co;
    endtask

    logic [W-1:0] rs;
    logic         rco;
    int           bc, edges;

    initial begin
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_s", s, 0);
        chk("rst_co", co, 0);
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // 5 + 3 + 0: 4 busy cycles, done at the 5th edge
        run_op(4'b0101, 4'b0011, 1'b0, rs, rco, bc, edges);
        chk("t27_s", rs, 4'b1000);
        chk("t27_co", rco, 0);
        chk("t27_busy_cycles", bc, 4);
        chk("t27_latency", edges, 5);

        run_op(4'b1111, 4'b0001, 1'b0, rs, rco, bc, edges);
        chk("t28a_s", rs, 4'b0000);
        chk("t28a_co", rco, 1);
        run_op(4'b1111, 4'b1111, 1'b1, rs, rco, bc, edges);
        chk("t28b_s", rs, 4'b1111);
        chk("t28b_co", rco, 1);

        // start held through RUN while inputs churn; then back-to-back from DONE
        begin
            logic got;
            got = 1'b0;
            @(negedge clk);
            start = 1'b1; a = 4'd2; b = 4'd3; ci = 1'b1;
            for (int i = 0; i < 20 && !got; i++) begin
                @(negedge clk);
                if (done) got = 1'b1;
                else begin
                    a  = 4'($urandom);
                    b  = 4'($urandom);
                    ci = 1'($urandom);
                end
            end
            if (!got) chk("t29_timeout", 0, 1);
            chk("t29_s", s, 6);
            chk("t29_co", co, 0);
            a = 4'd4; b = 4'd4; ci = 1'b0;
            @(negedge clk);
            chk("t29_b2b_busy", busy, 1);
            start = 1'b0;
            repeat (W) @(negedge clk);
            chk("t29_b2b_done", done, 1);
            chk("t29_b2b_s", s, 8);
            @(negedge clk);
        end

        // Abort during the second RUN cycle
        @(negedge clk);
        start = 1'b1; a = 4'd7; b = 4'd9; ci = 1'b0;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t30_busy", busy, 0);
        chk("t30_done", done, 0);
        chk("t30_s", s, 0);
        chk("t30_co", co, 0);
        @(negedge clk);
        rst = 1'b0;
        repeat (6) @(negedge clk);
        run_op(4'b0001, 4'b0001, 1'b0, rs, rco, bc, edges);
        chk("t30_s_after", rs, 4'b0010);
        chk("t30_co_after", rco, 0);
        chk("t30_latency_after", edges, 5);

        // Randomized traffic, checked only by the model
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            start = ($urandom_range(0, 2) == 0);
            a  = 4'($urandom);
            b  = 4'($urandom);
            ci = 1'($urandom);
        end
        @(negedge clk);
        start = 1'b0;
        repeat (W + 3) @(negedge clk);

        // Exhaustive sweep
        for (int i = 0; i < 512; i++) begin
            logic [W-1:0] ta, tb;
            logic         tci;
            int           exp_sum;
            ta  = 4'(i);
            tb  = 4'(i >> 4);
            tci = 1'(i >> 8);
            exp_sum = int'(ta) + int'(tb) + int'(tci);
            run_op(ta, tb, tci, rs, rco, bc, edges);
            chk("sweep", {27'd0, rco, rs}, exp_sum);
        end

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/serial_adder_4bit.md
SERIAL_ADDER_4BIT -- requirements
Module: serial_adder_4bit

Interface
REQ-001 Parameter: WIDTH, default 4, operand and sum width in bits; legal range 2..16.
REQ-002 One clock; reset is asynchronous and active-high.
REQ-003 clk  input  1  system clock; all state updates on its rising edge.
REQ-004 rst  input  1  asynchronous active-high reset.
REQ-005 start  input  1  request; sampled on rising clk edge.
REQ-006 a  input  WIDTH  operand A; sampled only when start is accepted.
REQ-007 b  input  WIDTH  operand B; sampled only when start is accepted.
REQ-008 ci  input  1  carry-in; sampled only when start is accepted.
REQ-009 busy  output  1  high while an addition is in progress (RUN state).
REQ-010 done  output  1  one-cycle pulse marking completion.
REQ-011 s  output  WIDTH  registered sum; held until the next completion.
REQ-012 co  output  1  registered carry-out; held until the next completion.

Function
REQ-013 The block SHALL compute {co,s} = a + b + ci bit-serially, one bit per clock, LSB first, using one full-adder cell (s = x^y^c, c' = (x^y)&c | x&y) and a 1-bit carry register.
REQ-014 FSM states SHALL be IDLE, RUN, DONE; no other encodings reachable.
REQ-015 IDLE: start=1 -> latch a, b into shift registers, ci into carry register, bit counter=0, go RUN; start=0 -> stay IDLE.
REQ-016 RUN: each edge SHALL consume bit 0 of both shift registers, shift them right by one, shift the sum bit into the MSB of the result shift register, update carry, and increment the counter.
REQ-017 RUN -> DONE on the edge that processes bit WIDTH-1; on that same edge s SHALL load the complete result and co the final carry.
REQ-018 DONE lasts exactly one cycle with done=1; then IDLE, unless start=1 in DONE, which SHALL latch new operands and go directly to RUN (back-to-back operation).
REQ-019 Latency: start sampled at edge E0 -> done high in the cycle following edge E(WIDTH); i.e. done asserts WIDTH+1 edges after start acceptance (5 for WIDTH=4).
REQ-020 start while busy=1 SHALL be ignored; a, b, ci changes during RUN SHALL NOT affect the result.
REQ-021 busy SHALL be 1 only in RUN; done SHALL be 1 only in DONE; busy and done never high together.
REQ-022 s and co SHALL change only on the REQ-017 edge; intermediate partial sums are never visible on s.
REQ-023 Counter width SHALL be ceil(log2(WIDTH))+1 bits; no wrap-around occurs within one operation.

Reset
REQ-024 rst=1 SHALL immediately, without a clock, force state=IDLE, busy=0, done=0, s=0, co=0, carry=0, counter=0, shift registers=0.
REQ-025 rst asserted mid-operation SHALL abort it; no done pulse is produced and s/co read 0.
REQ-026 After rst deasserts, the first start SHALL be accepted on the first rising edge with start=1.

Verification
REQ-027 a=0101, b=0011, ci=0, start 1 cycle -> busy high 4 cycles, done pulse at edge 5, s=1000, co=0.
REQ-028 a=1111, b=0001, ci=0 -> s=0000, co=1; a=1111, b=1111, ci=1 -> s=1111, co=1.
REQ-029 start held high through RUN with a changing each cycle -> single result for originally latched operands; start in DONE -> new operation begins, busy high the next cycle.
REQ-030 rst pulsed in the 2nd RUN cycle -> busy, done, s, co=0 immediately; no done pulse; subsequent a=0001, b=0001, ci=0 -> s=0010, co=0.
REQ-031 Exhaustive WIDTH=4 sweep of all a, b, ci (512 cases) -> {co,s} equals a+b+ci in every case; done exactly once per start.
